// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared defaults and width helper for the AXI-Stream FIFO slice
//
// Contents:
//   AXIS_DATA_WIDTH  default stream word width in bits
//   AXIS_SKID        default free-entry reserve, covers the one-cycle valid lag upstream
//   clog2()          ceiling log2, used to size pointers and the entry count

package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_SKID       = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// rtl/axis_fifo_ram.sv - FIFO storage array, synchronous write, asynchronous read
//
// Ports:
//   axi_clk  clock for the write port
//   we       write enable
//   waddr    write address
//   wdata    write data
//   raddr    read address
//   rdata    read data, combinational from raddr

module axis_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  axi_clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Contents are deliberately not reset; only the pointers define validity.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge axi_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_skid_fifo.sv
// rtl/axis_skid_fifo.sv - FWFT AXI-Stream FIFO with early ready drop and sticky overflow
//
// Ports:
//   axi_clk       clock, rising edge
//   axi_reset     synchronous active-high reset
//   s_axis_valid  upstream beat present
//   s_axis_data   upstream word
//   s_axis_ready  space advertisement, drops while SKID entries remain free
//   m_axis_valid  head of FIFO present
//   m_axis_data   head of FIFO word
//   m_axis_ready  downstream accepts
//   fill_level    current entry count, 0..DEPTH
//   overflow      sticky: a beat arrived while full and was discarded
//   overflow_clr  clears overflow

module axis_skid_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int SKID       = AXIS_SKID
) (
    input  logic                   axi_clk,
    input  logic                   axi_reset,
    input  logic                   s_axis_valid,
    input  logic [DATA_WIDTH-1:0]  s_axis_data,
    output logic                   s_axis_ready,
    output logic                   m_axis_valid,
    output logic [DATA_WIDTH-1:0]  m_axis_data,
    input  logic                   m_axis_ready,
    output logic [clog2(DEPTH):0]  fill_level,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic pop;
    logic push;
    logic full;
    logic drop;

    assign full = (count == CNT_W'(DEPTH));
    assign pop  = m_axis_valid & m_axis_ready;
    // Push ignores s_axis_ready: beats that arrive after ready falls still
    // land in the reserved skid entries. A pop frees a slot in the same edge.
    assign push = s_axis_valid & (~full | pop);
    assign drop = s_axis_valid & full & ~pop;

    // Ready comes from the count register only, so no input-to-output path.
    assign s_axis_ready = ~axi_reset & (count <= CNT_W'(DEPTH - 1 - SKID));
    assign m_axis_valid = (count != '0);
    assign fill_level   = count;

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // A fresh drop wins over a clear in the same cycle.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    axis_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .axi_clk (axi_clk),
        .we      (push & ~axi_reset),
        .waddr   (wr_ptr),
        .wdata   (s_axis_data),
        .raddr   (rd_ptr),
        .rdata   (m_axis_data)
    );

endmodule

// File: tb/tb_axis_skid_fifo.sv
// tb/tb_axis_skid_fifo.sv - scoreboard bench for axis_skid_fifo

module tb_axis_skid_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int SKID  = 1;

    logic          axi_clk = 1'b0;
    logic          axi_reset = 1'b1;
    logic          s_axis_valid = 1'b0;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_ready;
    logic          m_axis_valid;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_ready = 1'b0;
    logic [4:0]    fill_level;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] out_log[$];
    logic [DW-1:0] src_log[$];
    int            mdl_cnt = 0;
    bit            mdl_ovf = 1'b0;
    bit            m_pop, m_full, m_push;

    axis_skid_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .SKID       (SKID)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset    (axi_reset),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_ready (s_axis_ready),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_ready (m_axis_ready),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    // Reference model: a queue of stored words plus an entry count, advanced
    // at each rising edge from the inputs presented during that cycle.
    always @(posedge axi_clk) begin
        if (axi_reset) begin
            exp_q.delete();
            mdl_cnt = 0;
            mdl_ovf = 1'b0;
        end else begin
            m_pop  = (mdl_cnt != 0) && m_axis_ready;
            m_full = (mdl_cnt == DEPTH);
            m_push = s_axis_valid && (!m_full || m_pop);
            if (m_push) exp_q.push_back(s_axis_data);
            if (s_axis_valid && !m_push) mdl_ovf = 1'b1;
            else if (overflow_clr) mdl_ovf = 1'b0;
            mdl_cnt = mdl_cnt + int'(m_push) - int'(m_pop);
        end
    end

    // Monitor: mid-cycle sampling, pops the scoreboard on every handshake.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge axi_clk) begin
        check("s_axis_ready", {31'b0, s_axis_ready}, {31'b0, (!axi_reset && mdl_cnt <= DEPTH - 1 - SKID)});
        check("fill_level", {27'b0, fill_level}, mdl_cnt);
        check("m_axis_valid", {31'b0, m_axis_valid}, {31'b0, (mdl_cnt != 0)});
        check("overflow", {31'b0, overflow}, {31'b0, mdl_ovf});
        if (prev_stall) begin
            check("stall_valid", {31'b0, m_axis_valid}, 32'd1);
            check("stall_data", m_axis_data, prev_data);
        end
        if (!axi_reset && m_axis_valid && m_axis_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL pop_empty: got word %h expected no output", m_axis_data);
            end else begin
                check("m_axis_data", m_axis_data, exp_q.pop_front());
            end
            out_log.push_back(m_axis_data);
        end
        prev_stall = !axi_reset && m_axis_valid && !m_axis_ready;
        prev_data  = m_axis_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        int  cyc;
        bit  rdy_prev;
        bit  seen_bad;

        // Reset with valid held high
        axi_reset = 1'b1;
        s_axis_valid = 1'b1;
        s_axis_data = 32'h1234_5678;
        repeat (3) tick();
        check("rst_ready", {31'b0, s_axis_ready}, 32'd0);
        check("rst_valid", {31'b0, m_axis_valid}, 32'd0);
        check("rst_fill", {27'b0, fill_level}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        axi_reset = 1'b0;
        s_axis_valid = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, s_axis_ready}, 32'd1);

        // Fill 0x01..0x10 with the sink stalled
        m_axis_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            s_axis_valid = 1'b1;
            s_axis_data = i;
            tick();
            if (i == 14) check("ready_at_14", {31'b0, s_axis_ready}, 32'd1);
            if (i == 15) check("ready_at_15", {31'b0, s_axis_ready}, 32'd0);
        end
        s_axis_valid = 1'b0;
        check("fill_16", {27'b0, fill_level}, 32'd16);
        check("fill_no_ovf", {31'b0, overflow}, 32'd0);
        out_log.delete();
        m_axis_ready = 1'b1;
        repeat (17) tick();
        check("drain_empty", {31'b0, m_axis_valid}, 32'd0);
        check("drain_count", out_log.size(), 32'd16);
        for (int i = 0; i < out_log.size(); i++) check("drain_order", out_log[i], i + 1);

        // Overflow: drop while full, clear, clear racing a new drop
        m_axis_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_axis_valid = 1'b1;
            s_axis_data = 32'h100 + i;
            tick();
        end
        s_axis_data = 32'hDEAD_BEEF;
        tick();
        s_axis_valid = 1'b0;
        check("ovf_set", {31'b0, overflow}, 32'd1);
        check("ovf_fill", {27'b0, fill_level}, 32'd16);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_clr", {31'b0, overflow}, 32'd0);
        s_axis_valid = 1'b1;
        s_axis_data = 32'hDEAD_BEEF;
        overflow_clr = 1'b1;
        tick();
        s_axis_valid = 1'b0;
        overflow_clr = 1'b0;
        check("ovf_set_beats_clr", {31'b0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        out_log.delete();
        m_axis_ready = 1'b1;
        repeat (17) tick();
        check("ovf_drain_count", out_log.size(), 32'd16);
        seen_bad = 1'b0;
        for (int i = 0; i < out_log.size(); i++) begin
            if (out_log[i] == 32'hDEAD_BEEF) seen_bad = 1'b1;
        end
        check("dropped_never_out", {31'b0, seen_bad}, 32'd0);

        // Full pass-through: simultaneous push and pop at full
        m_axis_ready = 1'b0;
        out_log.delete();
        for (int i = 0; i < 16; i++) begin
            s_axis_valid = 1'b1;
            s_axis_data = 32'h200 + i;
            tick();
        end
        m_axis_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            s_axis_data = 32'h300 + j;
            tick();
            check("pass_fill", {27'b0, fill_level}, 32'd16);
        end
        s_axis_valid = 1'b0;
        repeat (17) tick();
        check("pass_count", out_log.size(), 32'd36);
        for (int i = 0; i < out_log.size(); i++)
            check("pass_order", out_log[i], (i < 16) ? (32'h200 + i) : (32'h300 + i - 16));
        check("pass_ovf", {31'b0, overflow}, 32'd0);

        // Random traffic, source honours ready with a one-cycle lag
        out_log.delete();
        src_log.delete();
        sent = 0;
        cyc = 0;
        rdy_prev = s_axis_ready;
        while (sent < 1000 && cyc < 20000) begin
            s_axis_valid = rdy_prev && ($urandom_range(0, 3) != 0);
            s_axis_data = $urandom;
            m_axis_ready = $urandom_range(0, 1) == 1;
            if (s_axis_valid) begin
                src_log.push_back(s_axis_data);
                sent++;
            end
            rdy_prev = s_axis_ready;
            tick();
            cyc++;
        end
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        cyc = 0;
        while (m_axis_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("rand_sent", sent, 32'd1000);
        check("rand_ovf", {31'b0, overflow}, 32'd0);
        check("rand_count", out_log.size(), src_log.size());
        for (int i = 0; i < out_log.size() && i < src_log.size(); i++)
            check("rand_order", out_log[i], src_log[i]);

        // Reset mid-stream discards buffered beats
        m_axis_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_axis_valid = 1'b1;
            s_axis_data = 32'h400 + i;
            tick();
        end
        s_axis_valid = 1'b0;
        axi_reset = 1'b1;
        tick();
        axi_reset = 1'b0;
        check("midrst_valid", {31'b0, m_axis_valid}, 32'd0);
        check("midrst_fill", {27'b0, fill_level}, 32'd0);
        out_log.delete();
        s_axis_valid = 1'b1;
        s_axis_data = 32'hA5A5_A5A5;
        tick();
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        repeat (3) tick();
        check("midrst_count", out_log.size(), 32'd1);
        if (out_log.size() > 0) check("midrst_first", out_log[0], 32'hA5A5_A5A5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
